// File: rtl/axis_home_seq_if.sv
// Signal bundle between the homing sequencer (slave side) and its requester
// plus the per-axis home managers (master side).
interface axis_home_seq_if #(
    parameter int NUM_AXES = 3
);
    logic                start;
    logic                abort;
    logic [NUM_AXES-1:0] axis_homed;
    logic [NUM_AXES-1:0] home_pulse;
    logic                busy;
    logic                done;
    logic                error;
    logic [2:0]          err_axis;

    modport master (
        output start, abort, axis_homed,
        input  home_pulse, busy, done, error, err_axis
    );

    modport slave (
        input  start, abort, axis_homed,
        output home_pulse, busy, done, error, err_axis
    );
endinterface

// File: rtl/axis_home_seq.sv
// Homing sequencer: homes axes from NUM_AXES-1 down to 0, un-homing first any axis already homed.
// Define HOME_TIMEOUT_EN to add a per-wait watchdog that parks the sequencer in FAULT.
module axis_home_seq #(
    parameter int          NUM_AXES       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000
) (
    input logic            clk,
    input logic            rst,
    axis_home_seq_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        UNHOME     = 3'd2,
        WAIT_LOW   = 3'd3,
        KICK       = 3'd4,
        WAIT_HOMED = 3'd5,
        NEXT       = 3'd6,
        FAULT      = 3'd7
    } state_t;

    localparam logic [2:0] LAST_AXIS = 3'(NUM_AXES - 1);

    if (NUM_AXES < 1 || NUM_AXES > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("axis_home_seq: NUM_AXES must be 1..8 and TIMEOUT_CYCLES at least 2");
    end

    state_t              state;
    logic [2:0]          idx;
    logic [7:0]          homed_ext;
    logic                cur_homed;
    logic [NUM_AXES-1:0] pulse_mask;

    // Widen to 8 bits so the 3-bit axis index never runs past the vector.
    assign homed_ext  = 8'(bus.axis_homed);
    assign cur_homed  = homed_ext[idx];
    assign pulse_mask = NUM_AXES'(8'd1 << idx);

`ifdef HOME_TIMEOUT_EN
    logic [31:0] wdog;
    logic        wdog_expired;
    logic        error_q;
    logic [2:0]  err_axis_q;

    assign wdog_expired = (wdog == 32'(TIMEOUT_CYCLES - 1));
    assign bus.error    = error_q;
    assign bus.err_axis = err_axis_q;
`else
    assign bus.error    = 1'b0;
    assign bus.err_axis = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= 3'd0;
            bus.home_pulse <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
`ifdef HOME_TIMEOUT_EN
            wdog           <= 32'd0;
            error_q        <= 1'b0;
            err_axis_q     <= 3'd0;
`endif
        end else begin
            bus.home_pulse <= '0;
            bus.done       <= 1'b0;
            // Abort beats everything except reset, including a simultaneous start.
            if (bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE, FAULT: begin
                        if (bus.start) begin
                            state    <= LOAD;
                            idx      <= LAST_AXIS;
                            bus.busy <= 1'b1;
`ifdef HOME_TIMEOUT_EN
                            error_q    <= 1'b0;
                            err_axis_q <= 3'd0;
`endif
                        end
                    end
                    LOAD: begin
                        state          <= cur_homed ? UNHOME : KICK;
                        bus.home_pulse <= pulse_mask;
                    end
                    UNHOME: begin
                        state <= WAIT_LOW;
`ifdef HOME_TIMEOUT_EN
                        wdog  <= 32'd0;
`endif
                    end
                    WAIT_LOW: begin
                        if (!cur_homed) begin
                            state          <= KICK;
                            bus.home_pulse <= pulse_mask;
                        end
`ifdef HOME_TIMEOUT_EN
                        else if (wdog_expired) begin
                            state      <= FAULT;
                            bus.busy   <= 1'b0;
                            error_q    <= 1'b1;
                            err_axis_q <= idx;
                        end else begin
                            wdog <= wdog + 32'd1;
                        end
`endif
                    end
                    KICK: begin
                        state <= WAIT_HOMED;
`ifdef HOME_TIMEOUT_EN
                        wdog  <= 32'd0;
`endif
                    end
                    WAIT_HOMED: begin
                        if (cur_homed) begin
                            state <= NEXT;
                        end
`ifdef HOME_TIMEOUT_EN
                        else if (wdog_expired) begin
                            state      <= FAULT;
                            bus.busy   <= 1'b0;
                            error_q    <= 1'b1;
                            err_axis_q <= idx;
                        end else begin
                            wdog <= wdog + 32'd1;
                        end
`endif
                    end
                    NEXT: begin
                        if (idx == 3'd0) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            state <= LOAD;
                            idx   <= idx - 3'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/axis_home_seq.md
AXIS_HOME_SEQ -- requirements
Module: axis_home_seq

Interface
REQ-001 Parameter NUM_AXES, default 3, number of axes sequenced; legal range 1..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd100_000_000, per-wait watchdog limit in clk cycles.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a full homing run; sampled on posedge clk.
REQ-006 abort  input  1  cancel the current run.
REQ-007 axis_homed  input  NUM_AXES  homed_output of each axis home manager.
REQ-008 home_pulse  output  NUM_AXES  one-cycle home request to each axis home manager.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse when all axes are homed.
REQ-011 error  output  1  sticky watchdog fault flag.
REQ-012 err_axis  output  3  index of the axis that faulted.

Function
REQ-013 States SHALL be IDLE, LOAD, UNHOME, WAIT_LOW, KICK, WAIT_HOMED, NEXT, FAULT.
REQ-014 Homing order SHALL be descending: axis NUM_AXES-1 first (Z before X/Y), axis 0 last.
REQ-015 IDLE: start=1 -> LOAD with idx=NUM_AXES-1, busy=1 next cycle, error cleared; start while busy SHALL be ignored.
REQ-016 LOAD: axis_homed[idx]=1 -> UNHOME; else -> KICK.
REQ-017 UNHOME: home_pulse[idx]=1 for exactly one cycle -> WAIT_LOW.
REQ-018 WAIT_LOW: axis_homed[idx]=0 -> KICK.
REQ-019 KICK: home_pulse[idx]=1 for exactly one cycle -> WAIT_HOMED.
REQ-020 WAIT_HOMED: axis_homed[idx]=1 -> NEXT.
REQ-021 NEXT: idx=0 -> IDLE with done=1 for one cycle and busy=0; else idx decrements -> LOAD.
REQ-022 home_pulse SHALL be registered, one-hot or zero, and never high in two consecutive cycles.
REQ-023 Minimum spacing between UNHOME and KICK pulses SHALL be 2 cycles, so the downstream manager sees two distinct edges.
REQ-024 abort=1 in any non-IDLE state -> IDLE next cycle; home_pulse=0, busy=0, done=0, error unchanged.
REQ-025 abort and start together in IDLE: abort wins and no run starts.
REQ-026 Deassertion of an already-sequenced axis_homed bit mid-run SHALL be ignored (no restart).
REQ-027 FAULT: busy=0, error=1, err_axis=idx held; exit only via start (new run) or rst.
REQ-028 The state register SHALL be 3-bit; unused encodings SHALL return to IDLE on the next cycle.

Reset
REQ-029 rst=1 SHALL force IDLE, idx=0, watchdog=0, home_pulse=0, busy=0, done=0, error=0, err_axis=0 on the next posedge.
REQ-030 rst SHALL take priority over start and abort; rst mid-run SHALL emit no further pulses.

Configuration
REQ-031 Macro HOME_TIMEOUT_EN; when defined, a 32-bit watchdog SHALL clear on entry to WAIT_LOW or WAIT_HOMED, increment each cycle in those states, and move to FAULT on the cycle it equals TIMEOUT_CYCLES-1 without the exit condition.
REQ-032 Without HOME_TIMEOUT_EN, no watchdog logic SHALL exist, WAIT states SHALL wait indefinitely, and error and err_axis SHALL be tied to 0.

Verification
REQ-033 NUM_AXES=3, all axis_homed=0, start pulse -> KICK pulses on home_pulse[2], [1], [0] in that order; each pulse follows the previous axis_homed rise; done pulses once.
REQ-034 axis_homed=3'b111, start -> for each axis, UNHOME pulse, model drops homed, then KICK pulse; exactly 6 pulses total, then done.
REQ-035 abort asserted in WAIT_HOMED on axis 1 -> busy=0 next cycle, no further pulses, done never asserted.
REQ-036 HOME_TIMEOUT_EN, TIMEOUT_CYCLES=50, axis 2 never homes -> error=1 and err_axis=2 exactly 50 cycles after WAIT_HOMED entry; start clears error.
REQ-037 rst asserted during KICK on axis 1 -> all outputs 0 next cycle; a following start restarts at axis 2.
REQ-038 start held high for 10 cycles through a run -> only one run executes; start remains ignored while busy.
